daq_frame_sender: RTL and testbench
===================================

// Module: daq_frame_sender
// PURPOSE
//  Upstream source for the spline-interpolation / peak-index core. Collects raw ADC samples
//  and buffers them in an internal FIFO. Emits one frame as POINT_NUM_Y rows of POINT_NUM_X
//  samples over a valid/ready stream, with start-of-frame, end-of-row and end-of-frame markers.
//  Sits between the ADC capture logic and the interpolation core; the core consumes rows.
// PARAMETERS
//  POINT_NUM_X   240  samples per row
//  POINT_NUM_Y   220  rows per frame
//  SAMPLE_BIT    16   sample width
//  FIFO_AW       8    FIFO address bits; depth = 2**FIFO_AW (must be >= 2)
// PORTS
//  sys_clk     in   1           single clock, all logic rising-edge
//  sys_rst     in   1           synchronous, active-high reset
//  start       in   1           pulse: arm a new frame (IDLE only)
//  abort       in   1           pulse: drop current frame, flush FIFO
//  adc_valid   in   1           ADC sample strobe
//  adc_data    in   SAMPLE_BIT  ADC sample
//  out_valid   out  1           stream valid
//  out_ready   in   1           stream ready from interpolation core
//  out_data    out  SAMPLE_BIT  stream sample
//  out_sof     out  1           first sample of frame (col 0, row 0)
//  out_last    out  1           last sample of row (col POINT_NUM_X-1)
//  out_eof     out  1           last sample of frame
//  busy        out  1           high in RUN
//  frame_done  out  1           one-cycle pulse after EOF transfer
//  row_idx     out  16          row of current out_data
//  ovf_cnt     out  16          samples dropped on FIFO full; saturates at 16'hFFFF
// BEHAVIOUR
//  - Reset: state=IDLE, FIFO empty, all outputs 0, ovf_cnt=0, row_idx=0.
//  - FSM IDLE->RUN on start (ovf_cnt, row/col counters, write count cleared on entry).
//    RUN->DONE on EOF handshake (out_valid & out_ready & out_eof). DONE->IDLE unconditionally; frame_done=1 in DONE.
//    abort in any state -> IDLE next cycle and FIFO flushed; abort wins over simultaneous start or EOF.
//    start outside IDLE is ignored.
//  - Write side: in IDLE/DONE adc samples discarded. In RUN a sample is written when adc_valid is high,
//    the FIFO is not full and write count < POINT_NUM_X*POINT_NUM_Y.
//    A sample is lost if the FIFO is full, write count not reached: ovf_cnt+1 (saturating).
//    Samples beyond X*Y are ignored and not counted.
//  - Read side: FIFO is first-word-fall-through. A sample written in cycle N drives out_valid in cycle N+1.
//    Transfer = out_valid & out_ready. While out_valid & !out_ready, out_data/out_sof/out_last/out_eof/row_idx
//    are held stable. out_valid never drops without a transfer, except on abort.
//  - Counters: col 0..POINT_NUM_X-1 wraps on transfer with out_last; row_idx increments at wrap.
//    out_eof = out_last & row_idx==POINT_NUM_Y-1. Counter widths derived with $clog2.
//  - Simultaneous FIFO write and read while full: read frees a slot but the write is still refused
//    (full is registered), so ovf_cnt increments.
//  - Throughput: 1 sample/cycle sustained when out_ready held high.
// CONFIGURATION
//  DAQ_FRAME_TEST_PATTERN_EN defined: adc_data ignored. Written value = (row*POINT_NUM_X + col) mod 2**SAMPLE_BIT
//    of the write position, so frames are a deterministic ramp. All other behaviour unchanged.
//  Undefined: adc_data written as received. No pattern logic is synthesised.
// TESTING
//  1 reset, then start, adc_valid=1 continuous, out_ready=1 -> 52800 transfers. out_sof only on the 1st,
//    out_last every 240th, out_eof on the 52800th. frame_done pulses 1 cycle later; ovf_cnt=0.
//  2 out_ready toggled 1-of-3 cycles, ADC continuous, FIFO_AW=4 -> ovf_cnt>0 and equals
//    samples offered minus samples accepted. Outputs stable during every stall; no duplicate or lost accepted samples.
//  3 DAQ_FRAME_TEST_PATTERN_EN, full frame -> out_data[k]=k mod 65536 for k=0..52799; row_idx=219 at eof.
//  4 abort at transfer 1000 (mid row 4) -> next cycle out_valid=0, busy=0. New start yields clean frame
//    beginning with out_sof and row_idx=0.
//  5 start and abort same cycle in IDLE -> stays IDLE. start pulsed while RUN -> ignored, frame count unaffected.
//  6 sys_rst asserted mid-frame, 1 cycle -> all outputs at reset values next cycle; ovf_cnt=0; FIFO empty.

Source files
------------

// File: rtl/daq_frame_sender.sv
// Frame sender: buffers ADC samples in a FWFT FIFO and streams one X*Y frame with sof/last/eof.
// Optional DAQ_FRAME_TEST_PATTERN_EN replaces adc_data with a ramp of the write position.
module daq_frame_sender #(
  parameter int POINT_NUM_X = 240,
  parameter int POINT_NUM_Y = 220,
  parameter int SAMPLE_BIT  = 16,
  parameter int FIFO_AW     = 8
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  adc_valid,
  input  logic [SAMPLE_BIT-1:0] adc_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SAMPLE_BIT-1:0] out_data,
  output logic                  out_sof,
  output logic                  out_last,
  output logic                  out_eof,
  output logic                  busy,
  output logic                  frame_done,
  output logic [15:0]           row_idx,
  output logic [15:0]           ovf_cnt
);

  localparam int TOTAL = POINT_NUM_X * POINT_NUM_Y;
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int CW    = FIFO_AW + 1;
  localparam int COLW  = (POINT_NUM_X > 1) ? $clog2(POINT_NUM_X) : 1;
  localparam int ROWW  = (POINT_NUM_Y > 1) ? $clog2(POINT_NUM_Y) : 1;
  localparam int WCW   = $clog2(TOTAL + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, stateNext;

  logic [SAMPLE_BIT-1:0] mem [DEPTH];
  logic [FIFO_AW-1:0]    wrPtr, rdPtr;
  logic [CW-1:0]         count;
  logic [WCW-1:0]        wrCnt;
  logic [COLW-1:0]       col;
  logic [ROWW-1:0]       row;
  logic [15:0]           ovfCnt;
  logic [SAMPLE_BIT-1:0] wrData;

  logic running, full, wrReq, wrEn, ovfHit;
  logic outValid, rdEn, lastCol, lastRow;
  logic eofXfer, enterRun;

  assign running  = (state == RUN);
  // full comes from the registered count, so a same-cycle read never
  // makes room for a write
  assign full     = (count == CW'(DEPTH));
  assign wrReq    = running & adc_valid & ~abort
                  & (wrCnt < WCW'(TOTAL));
  assign wrEn     = wrReq & ~full;
  assign ovfHit   = wrReq & full;
  assign outValid = running & (count != '0);
  assign rdEn     = outValid & out_ready;
  assign lastCol  = (col == COLW'(POINT_NUM_X - 1));
  assign lastRow  = (row == ROWW'(POINT_NUM_Y - 1));
  assign eofXfer  = rdEn & lastCol & lastRow;
  assign enterRun = (state == IDLE) & start & ~abort;

`ifdef DAQ_FRAME_TEST_PATTERN_EN
  assign wrData = SAMPLE_BIT'(wrCnt);
`else
  assign wrData = adc_data;
`endif

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (start)   stateNext = RUN;
      RUN:     if (eofXfer) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    if (abort) stateNext = IDLE;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= IDLE;
    else         state <= stateNext;
  end

  always_ff @(posedge sys_clk) begin
    if (wrEn) mem[wrPtr] <= wrData;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst || abort) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (wrEn) wrPtr <= wrPtr + FIFO_AW'(1);
      if (rdEn) rdPtr <= rdPtr + FIFO_AW'(1);
      unique case ({wrEn, rdEn})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst || enterRun) begin
      wrCnt  <= '0;
      col    <= '0;
      row    <= '0;
      ovfCnt <= '0;
    end else begin
      if (wrEn) wrCnt <= wrCnt + WCW'(1);
      if (ovfHit && ovfCnt != 16'hFFFF)
        ovfCnt <= ovfCnt + 16'd1;
      if (rdEn) begin
        if (lastCol) begin
          col <= '0;
          row <= lastRow ? '0 : row + ROWW'(1);
        end else begin
          col <= col + COLW'(1);
        end
      end
    end
  end

  assign out_valid  = outValid;
  assign out_data   = outValid ? mem[rdPtr] : '0;
  assign out_sof    = outValid & (col == '0) & (row == '0);
  assign out_last   = outValid & lastCol;
  assign out_eof    = outValid & lastCol & lastRow;
  assign busy       = running;
  assign frame_done = (state == DONE);
  assign row_idx    = 16'(row);
  assign ovf_cnt    = ovfCnt;

endmodule

// File: tb/tb_daq_frame_sender.sv
// Randomized bench for daq_frame_sender against a queue-based frame model.
// Small frame geometry keeps several complete frames short.
module tb_daq_frame_sender;

  localparam int X     = 12;
  localparam int Y     = 6;
  localparam int SB    = 16;
  localparam int AW    = 3;
  localparam int TOTAL = X * Y;
  localparam int DEPTH = 2 ** AW;

  logic          clk = 1'b0;
  logic          sys_rst, start, abort;
  logic          adc_valid, out_ready;
  logic [SB-1:0] adc_data;
  logic          out_valid, out_sof, out_last, out_eof;
  logic          busy, frame_done;
  logic [SB-1:0] out_data;
  logic [15:0]   row_idx, ovf_cnt;

  daq_frame_sender #(
    .POINT_NUM_X(X),
    .POINT_NUM_Y(Y),
    .SAMPLE_BIT (SB),
    .FIFO_AW    (AW)
  ) dut (
    .sys_clk   (clk),
    .sys_rst   (sys_rst),
    .start     (start),
    .abort     (abort),
    .adc_valid (adc_valid),
    .adc_data  (adc_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sof   (out_sof),
    .out_last  (out_last),
    .out_eof   (out_eof),
    .busy      (busy),
    .frame_done(frame_done),
    .row_idx   (row_idx),
    .ovf_cnt   (ovf_cnt)
  );

  always #5 clk = ~clk;

  int nCmp = 0;
  int nErr = 0;
  int gCyc = 0;

  // model: phase 0 idle, 1 run, 2 done
  int            mPhase = 0;
  int            mK = 0;
  int            mWritten = 0;
  int            mOvf = 0;
  bit            known = 0;
  bit            afterRst = 0;
  bit            sawDone = 0;
  logic [SB-1:0] q[$];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit expValid();
    return known && mPhase == 1 && q.size() > 0;
  endfunction

  task automatic compare();
    if (!known) return;
    chk("out_valid", 32'(out_valid), 32'(expValid()));
    chk("busy", 32'(busy), 32'(mPhase == 1));
    chk("frame_done", 32'(frame_done), 32'(mPhase == 2));
    chk("ovf_cnt", 32'(ovf_cnt), 32'(mOvf));
    if (frame_done) sawDone = 1;
    if (expValid()) begin
      chk("out_data", 32'(out_data), 32'(q[0]));
      chk("out_sof", 32'(out_sof), 32'(mK == 0));
      chk("out_last", 32'(out_last), 32'((mK % X) == X - 1));
      chk("out_eof", 32'(out_eof), 32'(mK == TOTAL - 1));
      chk("row_idx", 32'(row_idx), 32'(mK / X));
    end
    if (afterRst) begin
      chk("rst_data", 32'(out_data), 0);
      chk("rst_row", 32'(row_idx), 0);
      chk("rst_marks", 32'({out_sof, out_last, out_eof}), 0);
    end
  endtask

  task automatic modelStep();
    bit            xfer;
    bit            eofX;
    logic [SB-1:0] v;
    if (sys_rst) begin
      known = 1; afterRst = 1; mPhase = 0;
      mK = 0; mWritten = 0; mOvf = 0;
      q.delete();
      return;
    end
    afterRst = 0;
    if (!known) return;
    xfer = expValid() && out_ready;
    eofX = xfer && mK == TOTAL - 1;
    if (abort) begin
      mPhase = 0;
      q.delete();
      return;
    end
    case (mPhase)
      0: if (start) begin
        mPhase = 1; mK = 0; mWritten = 0; mOvf = 0;
      end
      1: begin
        if (adc_valid && mWritten < TOTAL) begin
          if (q.size() == DEPTH) begin
            if (mOvf < 65535) mOvf++;
          end else begin
`ifdef DAQ_FRAME_TEST_PATTERN_EN
            v = SB'(mWritten);
`else
            v = adc_data;
`endif
            q.push_back(v);
            mWritten++;
          end
        end
        if (xfer) begin
          void'(q.pop_front());
          mK++;
        end
        if (eofX) mPhase = 2;
      end
      default: mPhase = 0;
    endcase
  endtask

  task automatic cyc(input bit st, input bit ab, input bit av,
                     input bit rd, input bit rs);
    start = st; abort = ab; adc_valid = av;
    out_ready = rd; sys_rst = rs;
    adc_data = SB'($urandom);
    @(negedge clk);
    compare();
    @(posedge clk);
    modelStep();
    gCyc++;
    #1;
  endtask

  task automatic runFrame(input int avPct, input int rdyMode,
                          input int stPct, input int abortAt,
                          input int rstAt, input int budget);
    int n;
    bit st, ab, av, rd, rs, ended, expDone;
    sawDone = 0;
    ended = 0;
    expDone = (abortAt < 0) && (rstAt < 0);
    cyc(1, 0, 1, 1, 0);
    n = 0;
    while (n < budget && !ended) begin
      av = ($urandom_range(0, 99) < avPct);
      if (rdyMode == 0)      rd = 1;
      else if (rdyMode == 1) rd = (gCyc % 3 == 0);
      else                   rd = 1'($urandom_range(0, 1));
      st = ($urandom_range(0, 99) < stPct);
      ab = (abortAt >= 0) && (mK == abortAt) && (mPhase == 1);
      rs = (rstAt >= 0) && (mK == rstAt) && (mPhase == 1);
      cyc(st, ab, av, rd, rs);
      n++;
      if (mPhase == 0) ended = 1;
    end
    chk("frame_bound", 32'(ended), 1);
    chk("frame_done_seen", 32'(sawDone), 32'(expDone));
  endtask

  initial begin
    int ab;
    sys_rst = 1; start = 0; abort = 0;
    adc_valid = 0; out_ready = 0; adc_data = '0;
    repeat (3) cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 1, 1, 0);

    runFrame(100, 0, 0, -1, -1, TOTAL + 20);
    chk("full_rate_ovf", 32'(ovf_cnt), 0);

    runFrame(100, 1, 0, -1, -1, 30 * TOTAL);
    chk("stall_ovf_nonzero", 32'(ovf_cnt != 0), 1);

    runFrame(100, 0, 0, 2 * X + 6, -1, 30 * TOTAL);
    chk("abort_valid", 32'(out_valid), 0);
    chk("abort_busy", 32'(busy), 0);
    runFrame(70, 2, 0, -1, -1, 30 * TOTAL);

    cyc(1, 1, 1, 1, 0);
    cyc(0, 0, 1, 1, 0);
    chk("start_abort_idle", 32'(busy), 0);
    runFrame(80, 2, 25, -1, -1, 30 * TOTAL);

    runFrame(90, 2, 0, -1, 3 * X + 2, 30 * TOTAL);
    chk("rst_ovf", 32'(ovf_cnt), 0);
    chk("rst_valid", 32'(out_valid), 0);
    cyc(0, 0, 1, 1, 0);

    for (int i = 0; i < 8; i++) begin
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, TOTAL - 1) : -1;
      runFrame($urandom_range(30, 100), $urandom_range(0, 2),
               10, ab, -1, 30 * TOTAL);
      repeat ($urandom_range(0, 3)) cyc(0, 0, 1, 1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
